craft_round_constants_inv: RTL and testbench

CRAFT_ROUND_CONSTANTS_INV -- requirements
Module: craft_round_constants_inv

---
 rtl/craft_pkg.sv | 46 ++++
 rtl/craft_round_constants_inv.sv | 128 ++++++++++++
 tb/tb_craft_round_constants_inv.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/craft_pkg.sv
// Shared CRAFT round-constant definitions: LFSR widths, seeds, step functions
// and an elaboration-time lookup of the n-th forward LFSR state.
package craft_pkg;

  localparam int A_W   = 4;
  localparam int B_W   = 3;
  localparam int IDX_W = 5;
  localparam int RC_W  = 8;

  localparam logic [A_W-1:0] A_INIT = 4'h1;
  localparam logic [B_W-1:0] B_INIT = 3'h1;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } lfsr_t;

  function automatic logic [A_W-1:0] a_fwd(input logic [A_W-1:0] a);
    return {a[0] ^ a[1], a[3:1]};
  endfunction

  function automatic logic [A_W-1:0] a_bwd(input logic [A_W-1:0] a);
    return {a[2:0], a[3] ^ a[0]};
  endfunction

  function automatic logic [B_W-1:0] b_fwd(input logic [B_W-1:0] b);
    return {b[0] ^ b[1], b[2:1]};
  endfunction

  function automatic logic [B_W-1:0] b_bwd(input logic [B_W-1:0] b);
    return {b[1:0], b[2] ^ b[0]};
  endfunction

  // Walks the forward sequence n steps from the seeds; used for constants only.
  function automatic lfsr_t lfsr_at(input int n);
    lfsr_t s;
    s.a = A_INIT;
    s.b = B_INIT;
    for (int i = 0; i < n; i++) begin
      s.a = a_fwd(s.a);
      s.b = b_fwd(s.b);
    end
    return s;
  endfunction

endpackage

// File: rtl/craft_round_constants_inv.sv
// CRAFT round-constant generator, decryption order (ROUNDS-1 down to 0).
// Define CRAFT_RC_BIDIR_EN to add the dec port and forward-order sequencing.
module craft_round_constants_inv
  import craft_pkg::*;
#(
  parameter int ROUNDS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             start,
`ifdef CRAFT_RC_BIDIR_EN
  input  logic             dec,
`endif
  output logic [RC_W-1:0]  rc,
  output logic [IDX_W-1:0] round_idx,
  output logic             valid,
  output logic             last,
  output logic             done
);

  generate
    if (ROUNDS < 1 || ROUNDS > 32) begin : g_bad_rounds
      $error("craft_round_constants_inv: ROUNDS must be in 1..32");
    end
  endgenerate

  localparam lfsr_t            REV_LOAD = lfsr_at(ROUNDS - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(ROUNDS - 1);

  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             at_end;

`ifdef CRAFT_RC_BIDIR_EN
  logic dec_q, dec_d;

  assign at_end = dec_q ? (idx_q == '0) : (idx_q == IDX_TOP);
`else
  assign at_end = (idx_q == '0);
`endif

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef CRAFT_RC_BIDIR_EN
    dec_d   = dec_q;
`endif
    if (ce) begin
      if (start) begin
        valid_d = 1'b1;
        a_d     = REV_LOAD.a;
        b_d     = REV_LOAD.b;
        idx_d   = IDX_TOP;
`ifdef CRAFT_RC_BIDIR_EN
        dec_d   = dec;
        if (!dec) begin
          a_d   = A_INIT;
          b_d   = B_INIT;
          idx_d = '0;
        end
`endif
      end else if (valid_q) begin
        if (at_end) begin
          // Retire: park on the decryption-order load values, matching reset.
          valid_d = 1'b0;
          done_d  = 1'b1;
          a_d     = REV_LOAD.a;
          b_d     = REV_LOAD.b;
          idx_d   = IDX_TOP;
        end else begin
`ifdef CRAFT_RC_BIDIR_EN
          if (dec_q) begin
            a_d   = a_bwd(a_q);
            b_d   = b_bwd(b_q);
            idx_d = idx_q - 1'b1;
          end else begin
            a_d   = a_fwd(a_q);
            b_d   = b_fwd(b_q);
            idx_d = idx_q + 1'b1;
          end
`else
          a_d   = a_bwd(a_q);
          b_d   = b_bwd(b_q);
          idx_d = idx_q - 1'b1;
`endif
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= REV_LOAD.a;
      b_q     <= REV_LOAD.b;
      idx_q   <= IDX_TOP;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef CRAFT_RC_BIDIR_EN
      dec_q   <= 1'b1;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef CRAFT_RC_BIDIR_EN
      dec_q   <= dec_d;
`endif
    end
  end

  assign rc        = {a_q, 1'b0, b_q};
  assign round_idx = idx_q;
  assign valid     = valid_q;
  assign last      = valid_q & at_end;
  assign done      = done_q;

endmodule

// File: tb/tb_craft_round_constants_inv.sv
// Self-checking bench for craft_round_constants_inv; the reference model tracks
// only the round index and looks constants up in the published a/b sequences.
module tb_craft_round_constants_inv;

  localparam int R = 32;

  localparam logic [3:0] A_SEQ [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                                        4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};
  localparam logic [2:0] B_SEQ [7]  = '{3'h1, 3'h4, 3'h2, 3'h5, 3'h6, 3'h7, 3'h3};

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       start;
  logic [7:0] rc;
  logic [4:0] round_idx;
  logic       valid;
  logic       last;
  logic       done;
`ifdef CRAFT_RC_BIDIR_EN
  logic       dec;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int m_idx;
  bit m_valid;
  bit m_done;
  bit m_rev;

  craft_round_constants_inv #(.ROUNDS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .start     (start),
`ifdef CRAFT_RC_BIDIR_EN
    .dec       (dec),
`endif
    .rc        (rc),
    .round_idx (round_idx),
    .valid     (valid),
    .last      (last),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rc_tab(input int i);
    return {A_SEQ[i % 15], 1'b0, B_SEQ[i % 7]};
  endfunction

  function automatic int end_idx();
    return m_rev ? 0 : R - 1;
  endfunction

  // {valid, last, done, round_idx, rc}
  function automatic logic [15:0] exp_vec();
    logic e_last;
    e_last = m_valid && (m_idx == end_idx());
    return {m_valid, e_last, m_done, 5'(m_idx), rc_tab(m_idx)};
  endfunction

  function automatic logic [15:0] act_vec();
    return {valid, last, done, round_idx, rc};
  endfunction

  task automatic model_reset();
    m_idx   = R - 1;
    m_valid = 0;
    m_done  = 0;
    m_rev   = 1;
  endtask

  // Applies inputs, advances the model by one edge, then waits until 1 ns after the edge.
  task automatic drive_cycle(input bit c, input bit s);
    ce     = c;
    start  = s;
    m_done = 0;
    if (c) begin
      if (s) begin
`ifdef CRAFT_RC_BIDIR_EN
        m_rev = dec;
`else
        m_rev = 1;
`endif
        m_valid = 1;
        m_idx   = m_rev ? R - 1 : 0;
      end else if (m_valid) begin
        if (m_idx == end_idx()) begin
          m_valid = 0;
          m_done  = 1;
          m_idx   = R - 1;
        end else begin
          m_idx = m_rev ? m_idx - 1 : m_idx + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ce    = 1'b0;
    start = 1'b0;
`ifdef CRAFT_RC_BIDIR_EN
    dec   = 1'b1;
`endif
    model_reset();
    #2;
    n_cmp++;
    if (act_vec() !== {1'b0, 1'b0, 1'b0, 5'd31, rc_tab(31)}) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", act_vec(), {3'b000, 5'd31, rc_tab(31)});
    end
    ce = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL reset_held: got %h want %h", act_vec(), exp_vec());
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_sequence();
`ifdef CRAFT_RC_BIDIR_EN
    dec = 1'b1;
`endif
    drive_cycle(1, 1);
    for (int k = 0; k < R; k++) begin
      n_cmp++;
      if ({valid, last, done, round_idx, rc} !==
          {1'b1, (k == R - 1), 1'b0, 5'(R - 1 - k), rc_tab(R - 1 - k)}) begin
        n_bad++;
        $display("FAIL seq_step%0d: got v%b l%b d%b idx%0d rc%h want idx%0d rc%h last%b",
                 k, valid, last, done, round_idx, rc, R - 1 - k, rc_tab(R - 1 - k), (k == R - 1));
      end
      drive_cycle(1, 0);
    end
    n_cmp++;
    if ({valid, last, done, rc} !== {3'b001, rc_tab(R - 1)}) begin
      n_bad++;
      $display("FAIL seq_done: got v%b l%b d%b rc%h want v0 l0 d1 rc%h",
               valid, last, done, rc, rc_tab(R - 1));
    end
    drive_cycle(1, 0);
    n_cmp++;
    if ({valid, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL seq_done_pulse: got v%b d%b want v0 d0", valid, done);
    end
  endtask

  task automatic test_ce_gaps();
    bit pat [4] = '{1, 0, 0, 1};
`ifdef CRAFT_RC_BIDIR_EN
    dec = 1'b1;
`endif
    drive_cycle(1, 1);
    for (int k = 0; k < 3; k++) drive_cycle(1, 0);
    for (int k = 0; k < 4; k++) begin
      drive_cycle(pat[k], 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL ce_gap%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
    for (int guard = 0; guard < 200 && m_valid; guard++) begin
      drive_cycle(($urandom_range(0, 3) != 0), 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL ce_run: got %h want %h", act_vec(), exp_vec());
      end
    end
    // The retire edge needed ce=1; done must now clear on an edge with ce=0.
    drive_cycle(0, 0);
    n_cmp++;
    if ({done, valid} !== 2'b00) begin
      n_bad++;
      $display("FAIL ce_done_clear: got d%b v%b want d0 v0", done, valid);
    end
  endtask

  task automatic test_restart();
`ifdef CRAFT_RC_BIDIR_EN
    dec = 1'b1;
`endif
    drive_cycle(1, 1);
    while (m_idx != 10) drive_cycle(1, 0);
    n_cmp++;
    if (round_idx !== 5'd10) begin
      n_bad++;
      $display("FAIL restart_pre: got idx %0d want 10", round_idx);
    end
    drive_cycle(1, 1);
    n_cmp++;
    if ({valid, done, round_idx, rc} !== {2'b10, 5'd31, rc_tab(31)}) begin
      n_bad++;
      $display("FAIL restart: got v%b d%b idx%0d rc%h want v1 d0 idx31 rc%h",
               valid, done, round_idx, rc, rc_tab(31));
    end
    drive_cycle(1, 0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL restart_next: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
`ifdef CRAFT_RC_BIDIR_EN
    dec = 1'b1;
`endif
    drive_cycle(1, 1);
    repeat (5) drive_cycle(1, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (act_vec() !== {3'b000, 5'd31, rc_tab(31)}) begin
      n_bad++;
      $display("FAIL async_rst: got %h want %h", act_vec(), {3'b000, 5'd31, rc_tab(31)});
    end
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, 0);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL async_rst_idle%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
  endtask

`ifdef CRAFT_RC_BIDIR_EN
  task automatic test_forward();
    dec = 1'b0;
    drive_cycle(1, 1);
    dec = 1'b1;
    for (int k = 0; k < R; k++) begin
      n_cmp++;
      if ({valid, last, done, round_idx, rc} !==
          {1'b1, (k == R - 1), 1'b0, 5'(k), rc_tab(k)}) begin
        n_bad++;
        $display("FAIL fwd_step%0d: got v%b l%b d%b idx%0d rc%h want idx%0d rc%h",
                 k, valid, last, done, round_idx, rc, k, rc_tab(k));
      end
      drive_cycle(1, 0);
    end
    n_cmp++;
    if ({valid, done} !== 2'b01) begin
      n_bad++;
      $display("FAIL fwd_done: got v%b d%b want v0 d1", valid, done);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
`ifdef CRAFT_RC_BIDIR_EN
      dec = 1'($urandom);
`endif
      drive_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0));
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random%0d: got %h want %h", k, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ce_gaps();
    test_restart();
    test_async_reset();
`ifdef CRAFT_RC_BIDIR_EN
    test_forward();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
